keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 259 +++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 matrix keypad one column at a time, debounces a single key,
// and reports it once per press with a one-cycle pulse plus its row/column
// index. Only one key is tracked at a time: while a key is being debounced,
// held or released, every other key is ignored (no rollover).
//
// Parameters
//   SCAN_DIV        cycles each column is driven before its rows are sampled
//                   (must be >= 4)
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a press or a
//                   release (must be >= 2)
//   REPEAT_CYCLES   auto-repeat interval while a key stays held; only used
//                   when KEYPAD_AUTOREPEAT_EN is defined
//
// Optional feature
//   KEYPAD_AUTOREPEAT_EN  when defined, a held key re-emits button_pressed
//                         every REPEAT_CYCLES cycles. When undefined, each
//                         press yields exactly one pulse and no repeat
//                         counter exists.
//
// Ports
//   clk            in   system clock, all state on the rising edge
//   reset          in   asynchronous active-low reset
//   row_in[3:0]    in   row sense lines, active-low, asynchronous to clk
//   col_drive[3:0] out  column drive, one-hot active-low
//   button_pressed out  one-cycle pulse per accepted key event
//   row[1:0]       out  row index of the last accepted key
//   col[1:0]       out  column index of the last accepted key
//   key_held       out  high from acceptance until the release is accepted
// -----------------------------------------------------------------------------
module keypad_scanner #(
   parameter int unsigned SCAN_DIV        = 1000,
   parameter int unsigned DEBOUNCE_CYCLES = 100000,
   parameter int unsigned REPEAT_CYCLES   = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_in,
   output logic [3:0] col_drive,
   output logic       button_pressed,
   output logic [1:0] row,
   output logic [1:0] col,
   output logic       key_held
);

   // Counter widths: each counter only ever holds 0 .. PARAM-1.
   localparam int unsigned DIV_W = $clog2(SCAN_DIV);
   localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int unsigned      REP_W    = $clog2(REPEAT_CYCLES);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
`endif

   // Reject parameter values the counters and the sync latency cannot honour.
   if (SCAN_DIV < 4) begin : g_bad_scan_div
      $error("keypad_scanner: SCAN_DIV must be >= 4");
   end
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("keypad_scanner: DEBOUNCE_CYCLES must be >= 2");
   end
   if (REPEAT_CYCLES < 2) begin : g_bad_repeat
      $error("keypad_scanner: REPEAT_CYCLES must be >= 2");
   end

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   // Column index -> active-low one-hot drive pattern.
   function automatic logic [3:0] col_onehot_low(input logic [1:0] c);
      logic [3:0] drv;
      case (c)
         2'd0:    drv = 4'b1110;
         2'd1:    drv = 4'b1101;
         2'd2:    drv = 4'b1011;
         2'd3:    drv = 4'b0111;
         default: drv = 4'b1110;
      endcase
      return drv;
   endfunction

   logic [3:0]       row_meta_q;
   logic [3:0]       rs_q;
   state_t           state_q;
   logic [1:0]       col_sel_q;
   logic [1:0]       row_sel_q;
   logic [DIV_W-1:0] div_cnt_q;
   logic [DEB_W-1:0] deb_cnt_q;
   logic [3:0]       col_drive_q;
   logic             button_pressed_q;
   logic [1:0]       row_q;
   logic [1:0]       col_q;
   logic             key_held_q;
`ifdef KEYPAD_AUTOREPEAT_EN
   logic [REP_W-1:0] rep_cnt_q;
`endif

   logic [1:0] low_row_d;
   logic [1:0] col_inc_d;
   logic       key_line_d;

   // Two-flop synchronizer for the asynchronous row lines (idle = all high).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_meta_q <= 4'hF;
         rs_q       <= 4'hF;
      end else begin
         row_meta_q <= row_in;
         rs_q       <= row_meta_q;
      end
   end

   // Lowest-index low row wins when several rows are low together.
   always_comb begin
      low_row_d = 2'd0;
      if (!rs_q[0]) begin
         low_row_d = 2'd0;
      end else if (!rs_q[1]) begin
         low_row_d = 2'd1;
      end else if (!rs_q[2]) begin
         low_row_d = 2'd2;
      end else if (!rs_q[3]) begin
         low_row_d = 2'd3;
      end else begin
         low_row_d = 2'd0;
      end
   end

   // Next column in scan order (3 wraps to 0) and the tracked row line level.
   always_comb begin
      col_inc_d  = col_sel_q + 2'd1;
      key_line_d = rs_q[row_sel_q];
   end

   // Scanner/debounce FSM with all outputs registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= ST_SCAN;
         col_sel_q        <= 2'd0;
         row_sel_q        <= 2'd0;
         div_cnt_q        <= {DIV_W{1'b0}};
         deb_cnt_q        <= {DEB_W{1'b0}};
         col_drive_q      <= 4'b1110;
         button_pressed_q <= 1'b0;
         row_q            <= 2'd0;
         col_q            <= 2'd0;
         key_held_q       <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_cnt_q        <= {REP_W{1'b0}};
`endif
      end else begin
         button_pressed_q <= 1'b0;
         case (state_q)
            ST_SCAN: begin
               if (div_cnt_q == DIV_LAST) begin
                  div_cnt_q <= {DIV_W{1'b0}};
                  if (rs_q == 4'hF) begin
                     col_sel_q   <= col_inc_d;
                     col_drive_q <= col_onehot_low(col_inc_d);
                  end else begin
                     // Column stays driven; only row low_row_d is tracked now.
                     row_sel_q <= low_row_d;
                     deb_cnt_q <= {DEB_W{1'b0}};
                     state_q   <= ST_DEBOUNCE;
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + DIV_W'(1);
               end
            end

            ST_DEBOUNCE: begin
               if (key_line_d) begin
                  // Bounce or glitch: give up and move on to the next column.
                  deb_cnt_q   <= {DEB_W{1'b0}};
                  div_cnt_q   <= {DIV_W{1'b0}};
                  col_sel_q   <= col_inc_d;
                  col_drive_q <= col_onehot_low(col_inc_d);
                  state_q     <= ST_SCAN;
               end else if (deb_cnt_q == DEB_LAST) begin
                  deb_cnt_q        <= {DEB_W{1'b0}};
                  button_pressed_q <= 1'b1;
                  row_q            <= row_sel_q;
                  col_q            <= col_sel_q;
                  key_held_q       <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                  rep_cnt_q        <= {REP_W{1'b0}};
`endif
                  state_q          <= ST_HELD;
               end else begin
                  deb_cnt_q <= deb_cnt_q + DEB_W'(1);
               end
            end

            ST_HELD: begin
               if (key_line_d) begin
                  deb_cnt_q <= {DEB_W{1'b0}};
                  state_q   <= ST_RELEASE;
               end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                  if (rep_cnt_q == REP_LAST) begin
                     rep_cnt_q        <= {REP_W{1'b0}};
                     button_pressed_q <= 1'b1;
                  end else begin
                     rep_cnt_q <= rep_cnt_q + REP_W'(1);
                  end
`else
                  state_q <= ST_HELD;
`endif
               end
            end

            ST_RELEASE: begin
               if (!key_line_d) begin
                  // Release bounce: back to HELD silently, repeat timer restarts.
                  deb_cnt_q <= {DEB_W{1'b0}};
`ifdef KEYPAD_AUTOREPEAT_EN
                  rep_cnt_q <= {REP_W{1'b0}};
`endif
                  state_q   <= ST_HELD;
               end else if (deb_cnt_q == DEB_LAST) begin
                  deb_cnt_q   <= {DEB_W{1'b0}};
                  div_cnt_q   <= {DIV_W{1'b0}};
                  key_held_q  <= 1'b0;
                  col_sel_q   <= col_inc_d;
                  col_drive_q <= col_onehot_low(col_inc_d);
                  state_q     <= ST_SCAN;
               end else begin
                  deb_cnt_q <= deb_cnt_q + DEB_W'(1);
               end
            end

            default: begin
               state_q     <= ST_SCAN;
               col_sel_q   <= 2'd0;
               col_drive_q <= 4'b1110;
               div_cnt_q   <= {DIV_W{1'b0}};
               deb_cnt_q   <= {DEB_W{1'b0}};
               key_held_q  <= 1'b0;
            end
         endcase
      end
   end

   assign col_drive      = col_drive_q;
   assign button_pressed = button_pressed_q;
   assign row            = row_q;
   assign col            = col_q;
   assign key_held       = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8,
// REPEAT_CYCLES=32. A behavioural keypad pulls row_in[r] low whenever key
// (r,c) is pressed and col_drive[c] is low. Pulses are counted and
// time-stamped on the falling clock edge; stimulus runs 1 time unit after
// each falling edge.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 8;
   localparam int REP      = 32;
`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int EXP_HOLD100 = 4;
`else
   localparam int EXP_HOLD100 = 1;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] row_in;
   logic [3:0] col_drive;
   logic       button_pressed;
   logic [1:0] row;
   logic [1:0] col;
   logic       key_held;

   logic [15:0] pressed;
   int n_checks   = 0;
   int n_fail     = 0;
   int pulse_cnt  = 0;
   int cyc        = 0;
   int onehot_err = 0;
   int pulse_time[$];

   keypad_scanner #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_CYCLES  (REP)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .row_in        (row_in),
      .col_drive     (col_drive),
      .button_pressed(button_pressed),
      .row           (row),
      .col           (col),
      .key_held      (key_held)
   );

   always #5 clk = ~clk;

   // Keypad matrix model: key index is r*4+c.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && !col_drive[c]) begin
               row_in[r] = 1'b0;
            end
         end
      end
   end

   // Pulse counter / time stamps and column-drive shape monitor.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (button_pressed === 1'b1) begin
         pulse_cnt = pulse_cnt + 1;
         pulse_time.push_back(cyc);
      end
      if ($countones(col_drive) != 3) onehot_err = onehot_err + 1;
   end

   // Safety net against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_pulse(input string tag, input int budget, output int waited);
      logic found;
      found  = 1'b0;
      waited = 0;
      while (!found && waited < budget) begin
         step(1);
         waited++;
         if (button_pressed === 1'b1) found = 1'b1;
      end
      check_eq({tag, "_seen"}, 32'(found), 32'd1);
   endtask

   task automatic wait_col(input string tag, input logic [3:0] pat, input int budget);
      int n;
      n = 0;
      while (col_drive !== pat && n < budget) begin
         step(1);
         n++;
      end
      check_eq(tag, 32'(col_drive), 32'(pat));
   endtask

   task automatic wait_release(input string tag, input int budget);
      int n;
      n = 0;
      while (key_held !== 1'b0 && n < budget) begin
         step(1);
         n++;
      end
      check_eq(tag, 32'(key_held), 32'd0);
   endtask

   initial begin
      int w;
      int base;
      int t0;
      pressed = 16'h0000;
      reset   = 1'b1;
      #1 reset = 1'b0;
      step(2);
      check_eq("rst_col_drive", 32'(col_drive), 32'hE);
      check_eq("rst_pulse",     32'(button_pressed), 32'd0);
      check_eq("rst_key_held",  32'(key_held), 32'd0);
      check_eq("rst_row",       32'(row), 32'd0);
      check_eq("rst_col",       32'(col), 32'd0);
      reset = 1'b1;

      // Key (2,3) held ~100 cycles.
      base = pulse_cnt;
      pressed = 16'h0001 << 11;
      wait_pulse("s1_pulse", 60, w);
      check_eq("s1_row", 32'(row), 32'd2);
      check_eq("s1_col", 32'(col), 32'd3);
      check_eq("s1_held", 32'(key_held), 32'd1);
      step(99);
      check_eq("s1_pulse_count", 32'(pulse_cnt - base), 32'(EXP_HOLD100));
      check_eq("s1_held_late", 32'(key_held), 32'd1);
      pressed = 16'h0000;
      step(8);
      check_eq("s1_held_in_release", 32'(key_held), 32'd1);
      step(4);
      check_eq("s1_released", 32'(key_held), 32'd0);

      // Key (1,1) released partway through its debounce.
      wait_col("s2_at_col0", 4'b1110, 40);
      pressed = 16'h0001 << 5;
      wait_col("s2_at_col1", 4'b1101, 20);
      base = pulse_cnt;
      step(8);
      pressed = 16'h0000;
      w = 0;
      while (col_drive === 4'b1101 && w < 30) begin
         step(1);
         w++;
      end
      check_eq("s2_next_col", 32'(col_drive), 32'hB);
      step(2);
      check_eq("s2_no_pulse", 32'(pulse_cnt - base), 32'd0);

      // Keys (0,3) and (3,3) together: lowest row wins, other ignored.
      base = pulse_cnt;
      pressed = (16'h0001 << 3) | (16'h0001 << 15);
      wait_pulse("s3_pulse", 40, w);
      check_eq("s3_row", 32'(row), 32'd0);
      check_eq("s3_col", 32'(col), 32'd3);
      step(25);
      check_eq("s3_pulse_count", 32'(pulse_cnt - base), 32'd1);
      check_eq("s3_row_kept", 32'(row), 32'd0);
      pressed = 16'h0000;
      wait_release("s3_released", 30);

      // Key (3,0): reset mid-debounce, then fresh debounce.
      wait_col("s4_at_col1", 4'b1101, 30);
      pressed = 16'h0001 << 12;
      wait_col("s4_at_col0", 4'b1110, 30);
      step(7);
      base = pulse_cnt;
      reset = 1'b0;
      step(2);
      check_eq("s4_rst_col_drive", 32'(col_drive), 32'hE);
      check_eq("s4_rst_pulse", 32'(button_pressed), 32'd0);
      check_eq("s4_rst_col", 32'(col), 32'd0);
      check_eq("s4_no_pulse", 32'(pulse_cnt - base), 32'd0);
      reset = 1'b1;
      wait_pulse("s4_pulse", 40, w);
      check_eq("s4_fresh_debounce", 32'(w >= 10), 32'd1);
      check_eq("s4_row", 32'(row), 32'd3);
      check_eq("s4_col", 32'(col), 32'd0);
      check_eq("s4_pulse_count", 32'(pulse_cnt - base), 32'd1);
      pressed = 16'h0000;
      wait_release("s4_released", 30);

      // Key (2,1) with a one-cycle release bounce while held.
      pressed = 16'h0001 << 9;
      wait_pulse("s5_pulse", 40, w);
      base = pulse_cnt;
      step(10);
      pressed = 16'h0000;
      step(1);
      pressed = 16'h0001 << 9;
      step(20);
      check_eq("s5_no_second_pulse", 32'(pulse_cnt - base), 32'd0);
      check_eq("s5_still_held", 32'(key_held), 32'd1);
      pressed = 16'h0000;
      wait_release("s5_released", 30);

      // Key (2,1) held 100 cycles past acceptance (auto-repeat if enabled).
      pressed = 16'h0001 << 9;
      wait_pulse("s6_pulse", 40, w);
      base = pulse_cnt - 1;
      t0 = pulse_time[$];
      step(100);
      check_eq("s6_pulse_count", 32'(pulse_cnt - base), 32'(EXP_HOLD100));
      check_eq("s6_row", 32'(row), 32'd2);
      check_eq("s6_col", 32'(col), 32'd1);
`ifdef KEYPAD_AUTOREPEAT_EN
      check_eq("s6_repeat_gap", 32'(pulse_time[$] - pulse_time[$-1]), 32'd32);
      check_eq("s6_repeat_span", 32'(pulse_time[$] - t0), 32'd96);
`endif
      pressed = 16'h0000;
      wait_release("s6_released", 30);

      check_eq("col_drive_onehot", 32'(onehot_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
